rvlab_tlul_dma: RTL and testbench

// - Word-granular memory-to-memory copy engine acting as a TL-UL host (initiator).
// - Configured by the CPU through a TL-UL device register port on xbar_peri.
// - Its host port drives an xbar_main host slot, e.g. the student host slot.
// - Copies LEN bytes from SRC to DST, one word at a time, one transaction outstanding.
// - Raises irq_o on completion or bus error.

---
 rtl/rvlab_tlul_dma.sv | 224 ++++++++++++++++++++++
 tb/tb_rvlab_tlul_dma.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvlab_tlul_dma.sv
// Word-granular memory-to-memory copy engine: TL-UL register port for configuration,
// TL-UL host port issuing one Get/PutFullData pair per word, one transaction outstanding.
module rvlab_tlul_dma #(
  parameter int unsigned LenWidth = 16,
  parameter logic [7:0]  SourceId = 8'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // register port (device)
  input  logic        tl_dev_a_valid_i,
  input  logic [2:0]  tl_dev_a_opcode_i,
  input  logic [1:0]  tl_dev_a_size_i,
  input  logic [7:0]  tl_dev_a_source_i,
  input  logic [31:0] tl_dev_a_address_i,
  input  logic [3:0]  tl_dev_a_mask_i,
  input  logic [31:0] tl_dev_a_data_i,
  input  logic        tl_dev_d_ready_i,
  output logic        tl_dev_a_ready_o,
  output logic        tl_dev_d_valid_o,
  output logic [2:0]  tl_dev_d_opcode_o,
  output logic [1:0]  tl_dev_d_size_o,
  output logic [7:0]  tl_dev_d_source_o,
  output logic [31:0] tl_dev_d_data_o,
  output logic        tl_dev_d_error_o,
  // host port
  output logic        tl_host_a_valid_o,
  output logic [2:0]  tl_host_a_opcode_o,
  output logic [1:0]  tl_host_a_size_o,
  output logic [7:0]  tl_host_a_source_o,
  output logic [31:0] tl_host_a_address_o,
  output logic [3:0]  tl_host_a_mask_o,
  output logic [31:0] tl_host_a_data_o,
  output logic        tl_host_d_ready_o,
  input  logic        tl_host_a_ready_i,
  input  logic        tl_host_d_valid_i,
  input  logic [2:0]  tl_host_d_opcode_i,
  input  logic [31:0] tl_host_d_data_i,
  input  logic        tl_host_d_error_i,
  output logic        irq_o
);
  localparam int unsigned RW = LenWidth - 2;
  localparam logic [2:0] OpPutFull = 3'd0;
  localparam logic [2:0] OpPutPart = 3'd1;
  localparam logic [2:0] OpGet     = 3'd4;
  localparam logic [2:0] OpAck     = 3'd0;
  localparam logic [2:0] OpAckData = 3'd1;

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_RSP, S_WR_REQ, S_WR_RSP} state_e;

  state_e        r_state;
  logic [31:2]   r_src, r_dst, r_cur_src, r_cur_dst;
  logic [RW-1:0] r_len, r_remaining;
  logic          r_irq_en, r_done, r_err, r_irq;
  logic          r_h_valid;
  logic [2:0]    r_h_opcode;
  logic [31:0]   r_h_address, r_h_data;
  logic          r_d_valid, r_d_error;
  logic [2:0]    r_d_opcode;
  logic [1:0]    r_d_size;
  logic [7:0]    r_d_source;
  logic [31:0]   r_d_data;

  logic          w_busy, w_dev_a_ready, w_dev_acc, w_is_get, w_is_put, w_hit, w_wr, w_start;
  logic [9:0]    w_idx;
  logic [31:0]   w_rdata;
  logic [31:2]   w_next_src, w_next_dst;
  logic          w_unused;

  assign w_busy        = (r_state != S_IDLE);
  assign w_dev_a_ready = !r_d_valid || tl_dev_d_ready_i;
  assign w_dev_acc     = tl_dev_a_valid_i && w_dev_a_ready;
  assign w_is_get      = (tl_dev_a_opcode_i == OpGet);
  assign w_is_put      = (tl_dev_a_opcode_i == OpPutFull) || (tl_dev_a_opcode_i == OpPutPart);
  assign w_idx         = tl_dev_a_address_i[11:2];
  assign w_wr          = w_dev_acc && w_is_put && w_hit;
  assign w_start       = w_wr && (w_idx == 10'd3) && tl_dev_a_data_i[0] && !w_busy;
  assign w_next_src    = r_cur_src + 30'd1;
  assign w_next_dst    = r_cur_dst + 30'd1;
  assign w_unused      = ^{tl_dev_a_mask_i, tl_dev_a_address_i[31:12], tl_dev_a_address_i[1:0],
                           tl_host_d_opcode_i};

  // Register read mux and address decode
  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b1;
    case (w_idx)
      10'd0:   w_rdata = {r_src, 2'b00};
      10'd1:   w_rdata = {r_dst, 2'b00};
      10'd2:   w_rdata = 32'({r_len, 2'b00});
      10'd3:   w_rdata = {30'd0, r_irq_en, 1'b0};
      10'd4:   w_rdata = {29'd0, r_err, r_done, w_busy};
      default: w_hit   = 1'b0;
    endcase
  end

  // Register file, device response channel and copy FSM; FSM sets of DONE/ERR come last so they win over w1c
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_cur_src   <= '0;
      r_cur_dst   <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_irq       <= 1'b0;
      r_h_valid   <= 1'b0;
      r_h_opcode  <= OpGet;
      r_h_address <= '0;
      r_h_data    <= '0;
      r_d_valid   <= 1'b0;
      r_d_error   <= 1'b0;
      r_d_opcode  <= OpAck;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_data    <= '0;
    end else begin
      if (r_d_valid && tl_dev_d_ready_i) r_d_valid <= 1'b0;
      if (w_dev_acc) begin
        r_d_valid  <= 1'b1;
        r_d_opcode <= w_is_get ? OpAckData : OpAck;
        r_d_size   <= tl_dev_a_size_i;
        r_d_source <= tl_dev_a_source_i;
        r_d_data   <= (w_is_get && w_hit) ? w_rdata : 32'd0;
        r_d_error  <= !w_hit || !(w_is_get || w_is_put);
      end

      if (w_wr) begin
        case (w_idx)
          10'd0: if (!w_busy) r_src <= tl_dev_a_data_i[31:2];
          10'd1: if (!w_busy) r_dst <= tl_dev_a_data_i[31:2];
          10'd2: if (!w_busy) r_len <= tl_dev_a_data_i[LenWidth-1:2];
          10'd3: r_irq_en <= tl_dev_a_data_i[1];
          10'd4: begin
            if (tl_dev_a_data_i[1]) r_done <= 1'b0;
            if (tl_dev_a_data_i[2]) r_err  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (w_start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        if (r_len == '0) begin
          r_done <= 1'b1;
        end else begin
          r_cur_src   <= r_src;
          r_cur_dst   <= r_dst;
          r_remaining <= r_len;
          r_h_valid   <= 1'b1;
          r_h_opcode  <= OpGet;
          r_h_address <= {r_src, 2'b00};
          r_state     <= S_RD_REQ;
        end
      end

      case (r_state)
        S_RD_REQ: if (tl_host_a_ready_i) begin
          r_h_valid <= 1'b0;
          r_state   <= S_RD_RSP;
        end
        S_RD_RSP: if (tl_host_d_valid_i) begin
          if (tl_host_d_error_i) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_h_valid   <= 1'b1;
            r_h_opcode  <= OpPutFull;
            r_h_address <= {r_cur_dst, 2'b00};
            r_h_data    <= tl_host_d_data_i;
            r_state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: if (tl_host_a_ready_i) begin
          r_h_valid <= 1'b0;
          r_state   <= S_WR_RSP;
        end
        S_WR_RSP: if (tl_host_d_valid_i) begin
          if (tl_host_d_error_i) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cur_src   <= w_next_src;
            r_cur_dst   <= w_next_dst;
            r_remaining <= r_remaining - RW'(1);
            if (r_remaining == RW'(1)) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_h_valid   <= 1'b1;
              r_h_opcode  <= OpGet;
              r_h_address <= {w_next_src, 2'b00};
              r_state     <= S_RD_REQ;
            end
          end
        end
        default: ;
      endcase

      r_irq <= r_irq_en && (r_done || r_err);
    end
  end

  assign tl_dev_a_ready_o    = w_dev_a_ready;
  assign tl_dev_d_valid_o    = r_d_valid;
  assign tl_dev_d_opcode_o   = r_d_opcode;
  assign tl_dev_d_size_o     = r_d_size;
  assign tl_dev_d_source_o   = r_d_source;
  assign tl_dev_d_data_o     = r_d_data;
  assign tl_dev_d_error_o    = r_d_error;
  assign tl_host_a_valid_o   = r_h_valid;
  assign tl_host_a_opcode_o  = r_h_opcode;
  assign tl_host_a_size_o    = 2'd2;
  assign tl_host_a_source_o  = SourceId;
  assign tl_host_a_address_o = r_h_address;
  assign tl_host_a_mask_o    = 4'hF;
  assign tl_host_a_data_o    = r_h_data;
  assign tl_host_d_ready_o   = 1'b1;
  assign irq_o               = r_irq;
endmodule

// File: tb/tb_rvlab_tlul_dma.sv
// Bench for rvlab_tlul_dma: register vectors from a table, then directed copy scenarios
// against a zero/variable-wait memory slave on the host port.
module tb_rvlab_tlul_dma;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_a_valid, d_d_ready, d_a_ready, d_d_valid, d_d_error;
  logic [2:0]  d_a_opcode, d_d_opcode;
  logic [1:0]  d_a_size, d_d_size;
  logic [7:0]  d_a_source, d_d_source;
  logic [31:0] d_a_address, d_a_data, d_d_data;
  logic [3:0]  d_a_mask;
  logic        h_a_valid, h_d_ready, h_a_ready, h_d_valid, h_d_error;
  logic [2:0]  h_a_opcode, h_d_opcode;
  logic [1:0]  h_a_size;
  logic [7:0]  h_a_source;
  logic [31:0] h_a_address, h_a_data, h_d_data;
  logic [3:0]  h_a_mask;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;
  int n_get = 0, n_put = 0, n_avalid = 0;
  int err_at_get;
  logic [31:0] src_mem [256];
  logic [31:0] dst_mem [256];

  rvlab_tlul_dma #(.LenWidth(16), .SourceId(8'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tl_dev_a_valid_i(d_a_valid), .tl_dev_a_opcode_i(d_a_opcode), .tl_dev_a_size_i(d_a_size),
    .tl_dev_a_source_i(d_a_source), .tl_dev_a_address_i(d_a_address), .tl_dev_a_mask_i(d_a_mask),
    .tl_dev_a_data_i(d_a_data), .tl_dev_d_ready_i(d_d_ready), .tl_dev_a_ready_o(d_a_ready),
    .tl_dev_d_valid_o(d_d_valid), .tl_dev_d_opcode_o(d_d_opcode), .tl_dev_d_size_o(d_d_size),
    .tl_dev_d_source_o(d_d_source), .tl_dev_d_data_o(d_d_data), .tl_dev_d_error_o(d_d_error),
    .tl_host_a_valid_o(h_a_valid), .tl_host_a_opcode_o(h_a_opcode), .tl_host_a_size_o(h_a_size),
    .tl_host_a_source_o(h_a_source), .tl_host_a_address_o(h_a_address), .tl_host_a_mask_o(h_a_mask),
    .tl_host_a_data_o(h_a_data), .tl_host_d_ready_o(h_d_ready), .tl_host_a_ready_i(h_a_ready),
    .tl_host_d_valid_i(h_d_valid), .tl_host_d_opcode_i(h_d_opcode), .tl_host_d_data_i(h_d_data),
    .tl_host_d_error_i(h_d_error), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Memory slave: response one cycle after acceptance, optional error on a chosen Get
  always @(posedge clk) begin
    if (!rst_n) begin
      h_d_valid  <= 1'b0;
      h_d_error  <= 1'b0;
      h_d_data   <= '0;
      h_d_opcode <= '0;
    end else begin
      h_d_valid <= 1'b0;
      h_d_error <= 1'b0;
      if (h_a_valid) n_avalid <= n_avalid + 1;
      if (h_a_valid && h_a_ready) begin
        h_d_valid <= 1'b1;
        if (h_a_opcode == 3'd4) begin
          n_get      <= n_get + 1;
          h_d_data   <= src_mem[h_a_address[9:2]];
          h_d_error  <= ((n_get + 1) == err_at_get);
          h_d_opcode <= 3'd1;
        end else begin
          n_put                     <= n_put + 1;
          dst_mem[h_a_address[9:2]] <= h_a_data;
          h_d_opcode                <= 3'd0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic dev_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output logic [2:0] dop,
                          output logic [7:0] dsrc);
    int n;
    d_a_valid = 1'b1; d_a_opcode = wr ? 3'd0 : 3'd4; d_a_address = addr; d_a_data = wdata;
    d_a_source = 8'h5A; d_a_size = 2'd2; d_a_mask = 4'hF;
    n = 0;
    while (!d_a_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    d_a_valid = 1'b0;
    n = 0;
    while (!d_d_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!d_d_valid) begin
      n_checks++; n_fails++;
      $display("FAIL dev_timeout: no response for address %h", addr);
    end
    rdata = d_d_data; err = d_d_error; dop = d_d_opcode; dsrc = d_d_source;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd_v; logic e; logic [2:0] op; logic [7:0] s;
    dev_xfer(1'b1, addr, data, rd_v, e, op, s);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
    logic [2:0] op; logic [7:0] s;
    dev_xfer(1'b0, addr, 32'd0, data, err, op, s);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st; logic e; int n;
    st = 32'd1; n = 0;
    while (st[0] && n < 100) begin rd(32'h10, st, e); n++; end
    if (st[0]) begin
      n_checks++; n_fails++;
      $display("FAIL %s_idle_timeout: STATUS %h still busy", name, st);
    end
  endtask

  task automatic wait_req(input string name, input logic [2:0] op);
    int n;
    n = 0;
    while (!(h_a_valid && h_a_opcode == op) && n < 50) begin @(posedge clk); #1; n++; end
    if (!(h_a_valid && h_a_opcode == op)) begin
      n_checks++; n_fails++;
      $display("FAIL %s_req_timeout: no host request with opcode %0d", name, op);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] v, a0, dat0;
    logic        e;
    logic [2:0]  op;
    logic [7:0]  s;
    int          g0, p0, av0;

    vecs[0]  = '{1'b1, 32'h00, 32'h1234_5677, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h00, 32'h0, 32'h1234_5674, 1'b0};
    vecs[2]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h04, 32'h0, 32'hFFFF_FFFC, 1'b0};
    vecs[4]  = '{1'b1, 32'h08, 32'h0001_2347, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h08, 32'h0, 32'h0000_2344, 1'b0};
    vecs[6]  = '{1'b1, 32'h0C, 32'h2, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0C, 32'h0, 32'h2, 1'b0};
    vecs[8]  = '{1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h14, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 32'h20, 32'h1, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 32'h0C, 32'h0, 32'h2, 1'b0};
    vecs[12] = '{1'b1, 32'h0C, 32'h0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0C, 32'h0, 32'h0, 1'b0};

    for (int i = 0; i < 256; i++) src_mem[i] = 32'hC0DE_0000 + 32'(i);
    src_mem[0] = 32'h11; src_mem[1] = 32'h22; src_mem[2] = 32'h33; src_mem[3] = 32'h44;
    src_mem[4] = 32'h55; src_mem[5] = 32'h66; src_mem[6] = 32'h77; src_mem[7] = 32'h88;
    err_at_get = 0;
    h_a_ready = 1'b1; d_d_ready = 1'b1;
    d_a_valid = 1'b0; d_a_opcode = '0; d_a_size = '0; d_a_source = '0;
    d_a_address = '0; d_a_mask = '0; d_a_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_h_a_valid", 32'(h_a_valid), 32'd0);
    chk("rst_h_d_ready", 32'(h_d_ready), 32'd1);
    chk("rst_d_a_ready", 32'(d_a_ready), 32'd1);
    chk("rst_d_d_valid", 32'(d_d_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    // Register map vectors
    for (int i = 0; i < 14; i++) begin
      dev_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, v, e, op, s);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_opcode", i), 32'(op), vecs[i].wr ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d_source", i), 32'(s), 32'h5A);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), v, vecs[i].exp_rdata);
    end

    // 16-byte copy
    g0 = n_get; p0 = n_put;
    wr(32'h00, 32'h1000_0000); wr(32'h04, 32'h1000_0100); wr(32'h08, 32'd16);
    wr(32'h0C, 32'h1);
    wait_idle("copy16");
    chk("copy16_gets", 32'(n_get - g0), 32'd4);
    chk("copy16_puts", 32'(n_put - p0), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("copy16_dst%0d", i), dst_mem[64 + i], src_mem[i]);
    rd(32'h10, v, e); chk("copy16_status", v, 32'h2);
    chk("copy16_irq_off", 32'(irq), 32'd0);
    wr(32'h10, 32'h2);
    rd(32'h10, v, e); chk("done_w1c", v, 32'h0);

    // LEN=0 with IRQ_EN
    g0 = n_get; av0 = n_avalid;
    wr(32'h08, 32'd0); wr(32'h0C, 32'h3);
    rd(32'h10, v, e); chk("len0_status", v, 32'h2);
    chk("len0_irq_on", 32'(irq), 32'd1);
    chk("len0_no_avalid", 32'(n_avalid - av0), 32'd0);
    wr(32'h10, 32'h2);
    chk("len0_irq_still_high", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("len0_irq_cleared", 32'(irq), 32'd0);
    wr(32'h0C, 32'h0);

    // Error on second Get of an 8-word copy
    g0 = n_get; p0 = n_put;
    err_at_get = n_get + 2;
    wr(32'h00, 32'h1000_0000); wr(32'h04, 32'h1000_0180); wr(32'h08, 32'd32);
    wr(32'h0C, 32'h1);
    wait_idle("err");
    err_at_get = 0;
    rd(32'h10, v, e); chk("err_status", v, 32'h4);
    chk("err_puts", 32'(n_put - p0), 32'd1);
    chk("err_gets", 32'(n_get - g0), 32'd2);
    wr(32'h10, 32'h4);
    rd(32'h10, v, e); chk("err_w1c", v, 32'h0);

    // a_ready stalls on both request phases
    p0 = n_put;
    h_a_ready = 1'b0;
    wr(32'h00, 32'h1000_0010); wr(32'h04, 32'h1000_0200); wr(32'h08, 32'd8);
    wr(32'h0C, 32'h1);
    wait_req("stall_rd", 3'd4);
    a0 = h_a_address;
    chk("stall_rd_addr", a0, 32'h1000_0010);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_rd_hold%0d", i), h_a_valid ? h_a_address : 32'hFFFF_FFFF, a0);
    end
    h_a_ready = 1'b1;
    @(posedge clk); #1;
    h_a_ready = 1'b0;
    wait_req("stall_wr", 3'd0);
    a0 = h_a_address; dat0 = h_a_data;
    chk("stall_wr_addr", a0, 32'h1000_0200);
    chk("stall_wr_data", dat0, src_mem[4]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_wr_hold_addr%0d", i), h_a_valid ? h_a_address : 32'hFFFF_FFFF, a0);
      chk($sformatf("stall_wr_hold_data%0d", i), h_a_data, dat0);
    end
    h_a_ready = 1'b1;
    wait_idle("stall");
    chk("stall_puts", 32'(n_put - p0), 32'd2);
    chk("stall_dst0", dst_mem[128], src_mem[4]);
    chk("stall_dst1", dst_mem[129], src_mem[5]);
    rd(32'h10, v, e); chk("stall_status", v, 32'h2);

    // Writes while busy are ignored; unmapped read errors
    p0 = n_put;
    wr(32'h00, 32'h1000_0000); wr(32'h04, 32'h1000_0280); wr(32'h08, 32'd32);
    wr(32'h0C, 32'h1);
    rd(32'h10, v, e); chk("busy_status", v, 32'h1);
    wr(32'h00, 32'hDEAD_BEE0);
    rd(32'h00, v, e); chk("busy_src_kept", v, 32'h1000_0000);
    rd(32'h14, v, e);
    chk("unmapped_err", 32'(e), 32'd1);
    chk("unmapped_data", v, 32'h0);
    wait_idle("busy");
    chk("busy_puts", 32'(n_put - p0), 32'd8);
    chk("busy_dst7", dst_mem[167], src_mem[7]);

    // Reset mid-copy, then a clean restart
    wr(32'h00, 32'h1000_0000); wr(32'h04, 32'h1000_0300); wr(32'h08, 32'd32);
    wr(32'h0C, 32'h3);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_avalid", 32'(h_a_valid), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    rd(32'h10, v, e); chk("rst_mid_status", v, 32'h0);
    rd(32'h00, v, e); chk("rst_mid_src", v, 32'h0);
    for (int i = 0; i < 4; i++) src_mem[i] = 32'hA000_0000 + 32'(i);
    p0 = n_put;
    wr(32'h00, 32'h1000_0000); wr(32'h04, 32'h1000_0300); wr(32'h08, 32'd16);
    wr(32'h0C, 32'h1);
    wait_idle("restart");
    chk("restart_puts", 32'(n_put - p0), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("restart_dst%0d", i), dst_mem[192 + i], 32'hA000_0000 + 32'(i));
    rd(32'h10, v, e); chk("restart_status", v, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
